product_accumulator: RTL and testbench

Streaming accumulator that sits directly downstream of the parameterized multiplier. It sums a programmable number of unsigned products and emits one frame sum per frame. Input and output use a valid/ready handshake, and there is a sticky overflow flag per frame. It turns raw multiplier output into dot-product / integrate-and-dump results for the datapath.

---
 rtl/dsp_pkg.sv | 22 ++
 rtl/sat_adder.sv | 21 ++
 rtl/product_accumulator.sv | 151 +++++++++++++++
 tb/tb_product_accumulator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared types and helpers for the product accumulator datapath.
//   acc_state_e          : frame FSM state (IDLE = no partial frame, ACCUM = frame in progress)
//   acc_guard_bits()     : guard bits needed so a full frame of products cannot overflow
//   default_acc_width()  : recommended accumulator width (data width plus guard bits)
package dsp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // A frame holds at most 2^len_width-1 products, so len_width extra bits
   // are enough to hold the worst-case sum without a carry out.
   function automatic int acc_guard_bits(input int len_width);
      return len_width;
   endfunction

   function automatic int default_acc_width(input int data_width, input int len_width);
      return data_width + acc_guard_bits(len_width);
   endfunction

endpackage

// File: rtl/sat_adder.sv
// sat_adder: combinational WIDTH-bit unsigned adder with carry out.
//   a, b    : unsigned operands
//   sum     : a+b modulo 2^WIDTH, or all-ones on carry when SATURATE=1
//   carry_o : carry out of the WIDTH-bit add (overflow indication)
module sat_adder #(
   parameter int WIDTH    = 40,
   parameter bit SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry_o
);

   logic [WIDTH:0] sum_full;

   assign sum_full = {1'b0, a} + {1'b0, b};
   assign carry_o  = sum_full[WIDTH];
   assign sum      = (SATURATE && carry_o) ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmable number of unsigned products per
// frame and emits one frame sum with a sticky per-frame overflow flag.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clear_i        : synchronous abort of the partial frame and pending output
//   len_i          : products per frame, sampled on a frame's first accept (0 means 1)
//   data_i/valid_i/ready_o : input product stream
//   data_o/overflow_o/valid_o/ready_i : output frame sum stream
//   dbg_state_o    : current frame FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid (and its data) until that edge; ready may
// depend combinationally on the consumer's ready (ready_o follows ready_i so
// the output register drains in the same cycle a new sample enters).
module product_accumulator
   import dsp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int LEN_WIDTH  = 8,
   parameter bit SATURATE   = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clear_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [ACC_WIDTH-1:0]  data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  overflow_o,
   output acc_state_e            dbg_state_o
);

   acc_state_e           state_q, state_n;
   logic [ACC_WIDTH-1:0] acc_q, acc_n;
   logic [ACC_WIDTH-1:0] data_ext, add_sum, end_sum;
   logic                 add_carry;
   logic                 ovf_q, ovf_n, end_ovf;
   logic                 frame_end, accept;
   logic [LEN_WIDTH:0]   cnt_q, cnt_n, cnt_inc;
   logic [LEN_WIDTH-1:0] len_q, len_n, len_eff;

   assign ready_o     = !clear_i && (!valid_o || ready_i);
   assign accept      = valid_i && ready_o;
   assign data_ext    = ACC_WIDTH'(data_i);
   assign len_eff     = (len_i == '0) ? LEN_WIDTH'(1) : len_i;
   assign cnt_inc     = cnt_q + 1'b1;
   assign dbg_state_o = state_q;

   sat_adder #(
      .WIDTH    (ACC_WIDTH),
      .SATURATE (SATURATE)
   ) u_sat_adder (
      .a       (acc_q),
      .b       (data_ext),
      .sum     (add_sum),
      .carry_o (add_carry)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_n;
         acc_q   <= acc_n;
         ovf_q   <= ovf_n;
         cnt_q   <= cnt_n;
         len_q   <= len_n;
      end
   end

   // Next-state logic. On a frame end the accumulator, count and flag are
   // returned to zero so the next frame starts clean.
   always_comb begin
      state_n   = state_q;
      acc_n     = acc_q;
      ovf_n     = ovf_q;
      cnt_n     = cnt_q;
      len_n     = len_q;
      frame_end = 1'b0;
      end_sum   = add_sum;
      end_ovf   = 1'b0;
      if (clear_i) begin
         state_n = IDLE;
         acc_n   = '0;
         ovf_n   = 1'b0;
         cnt_n   = '0;
      end else if (accept) begin
         unique case (state_q)
            IDLE: begin
               len_n = len_eff;
               if (len_eff == LEN_WIDTH'(1)) begin
                  frame_end = 1'b1;
                  end_sum   = data_ext;
                  end_ovf   = 1'b0;
                  acc_n     = '0;
                  ovf_n     = 1'b0;
                  cnt_n     = '0;
               end else begin
                  state_n = ACCUM;
                  acc_n   = data_ext;
                  ovf_n   = 1'b0;
                  cnt_n   = (LEN_WIDTH+1)'(1);
               end
            end
            ACCUM: begin
               if (cnt_inc == {1'b0, len_q}) begin
                  frame_end = 1'b1;
                  end_sum   = add_sum;
                  end_ovf   = ovf_q | add_carry;
                  state_n   = IDLE;
                  acc_n     = '0;
                  ovf_n     = 1'b0;
                  cnt_n     = '0;
               end else begin
                  acc_n = add_sum;
                  ovf_n = ovf_q | add_carry;
                  cnt_n = cnt_inc;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Output register: a completing frame always wins over the drain so the
   // back-to-back case keeps valid_o high with fresh data.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_o     <= '0;
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (clear_i) begin
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (frame_end) begin
         data_o     <= end_sum;
         overflow_o <= end_ovf;
         valid_o    <= 1'b1;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;
   import dsp_pkg::*;

   localparam int DW = 32;
   localparam int AW = 40;
   localparam int LW = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic          clear, valid, ready_in;
   logic [LW-1:0] len;
   logic [DW-1:0] data;

   logic          m_ready, m_valid, m_ovf;
   logic [AW-1:0] m_data;
   acc_state_e    m_state;
   logic          w_ready, w_valid, w_ovf;
   logic [7:0]    w_data;
   acc_state_e    w_state;
   logic          s_ready, s_valid, s_ovf;
   logic [7:0]    s_data;
   acc_state_e    s_state;

   product_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .SATURATE(1'b0)) dut_main (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .len_i(len), .data_i(data),
      .valid_i(valid), .ready_o(m_ready), .data_o(m_data), .valid_o(m_valid),
      .ready_i(ready_in), .overflow_o(m_ovf), .dbg_state_o(m_state));

   product_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(LW), .SATURATE(1'b0)) dut_wrap (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .len_i(len), .data_i(data[7:0]),
      .valid_i(valid), .ready_o(w_ready), .data_o(w_data), .valid_o(w_valid),
      .ready_i(ready_in), .overflow_o(w_ovf), .dbg_state_o(w_state));

   product_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(LW), .SATURATE(1'b1)) dut_sat (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .len_i(len), .data_i(data[7:0]),
      .valid_i(valid), .ready_o(s_ready), .data_o(s_data), .valid_o(s_valid),
      .ready_i(ready_in), .overflow_o(s_ovf), .dbg_state_o(s_state));

   // ---------------- scoreboard counters ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int v, input int d, input int l, input int r, input int c);
      valid    = (v != 0);
      data     = DW'(d);
      len      = LW'(l);
      ready_in = (r != 0);
      clear    = (c != 0);
      step();
   endtask

   // Async reset pulse placed between clock edges (called at posedge+1).
   task automatic reset_assert();
      #2 rst_n = 1'b0;
      #1;
   endtask

   task automatic reset_release();
      #2 rst_n = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic [LW-1:0] l;
      logic          r;
      logic          c;
      logic          e_rdy;
      logic          e_v;
      logic [AW-1:0] e_d;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input int v, input int d, input int l, input int r, input int c,
                          input int e_rdy, input int e_v, input longint e_d);
      vec_t x;
      x.v = (v != 0); x.d = DW'(d); x.l = LW'(l); x.r = (r != 0); x.c = (c != 0);
      x.e_rdy = (e_rdy != 0); x.e_v = (e_v != 0); x.e_d = AW'(e_d);
      tbl.push_back(x);
   endtask

   initial begin
      // frame of 4: 10+20+30+40
      add_vec(1, 10, 4, 1, 0, 1, 0, 0);
      add_vec(1, 20, 4, 1, 0, 1, 0, 0);
      add_vec(1, 30, 4, 1, 0, 1, 0, 0);
      add_vec(1, 40, 4, 1, 0, 1, 1, 100);
      add_vec(0,  0, 4, 1, 0, 1, 0, 100);
      // len 1, continuous
      add_vec(1, 7, 1, 1, 0, 1, 1, 7);
      add_vec(1, 8, 1, 1, 0, 1, 1, 8);
      add_vec(1, 9, 1, 1, 0, 1, 1, 9);
      add_vec(0, 0, 1, 1, 0, 1, 0, 9);
      // backpressure: 5+6 held, stall, then 1+2
      add_vec(1, 5, 2, 0, 0, 1, 0, 9);
      add_vec(1, 6, 2, 0, 0, 1, 1, 11);
      add_vec(1, 1, 2, 0, 0, 0, 1, 11);
      add_vec(1, 1, 2, 0, 0, 0, 1, 11);
      add_vec(1, 1, 2, 1, 0, 1, 0, 11);
      add_vec(1, 2, 2, 1, 0, 1, 1, 3);
      // drain and frame end in the same cycle
      add_vec(1, 4, 2, 1, 0, 1, 0, 3);
      add_vec(1, 5, 2, 1, 0, 1, 1, 9);
      add_vec(1, 5, 1, 1, 0, 1, 1, 5);
      add_vec(0, 0, 1, 1, 0, 1, 0, 5);
      // clear mid-frame, then 1+2+3+4
      add_vec(1, 100, 4, 1, 0, 1, 0, 5);
      add_vec(1, 100, 4, 1, 0, 1, 0, 5);
      add_vec(1,  55, 4, 1, 1, 0, 0, 5);
      add_vec(1,   1, 4, 1, 0, 1, 0, 5);
      add_vec(1,   2, 4, 1, 0, 1, 0, 5);
      add_vec(1,   3, 4, 1, 0, 1, 0, 5);
      add_vec(1,   4, 4, 1, 0, 1, 1, 10);
      add_vec(0,   0, 4, 1, 0, 1, 0, 10);
      // clear drops a pending output, data_o holds
      add_vec(1, 3, 1, 0, 0, 1, 1, 3);
      add_vec(0, 0, 1, 0, 1, 0, 0, 3);
      // len 0 behaves as len 1
      add_vec(1, 6, 0, 1, 0, 1, 1, 6);
      add_vec(0, 0, 0, 1, 0, 1, 0, 6);

      // reset
      rst_n = 1'b0; clear = 1'b0; valid = 1'b0; ready_in = 1'b1; len = '0; data = '0;
      #22 rst_n = 1'b1;
      #1;
      check("reset data_o", 64'(m_data), 64'd0);
      check("reset valid_o", 64'(m_valid), 64'd0);
      check("reset overflow_o", 64'(m_ovf), 64'd0);
      check("reset ready_o", 64'(m_ready), 64'd1);
      check("reset state", 64'(m_state), 64'(IDLE));
      step();

      // table
      foreach (tbl[i]) begin
         valid    = tbl[i].v;
         data     = tbl[i].d;
         len      = tbl[i].l;
         ready_in = tbl[i].r;
         clear    = tbl[i].c;
         #1;
         check($sformatf("vec%0d ready_o", i), 64'(m_ready), 64'(tbl[i].e_rdy));
         step();
         check($sformatf("vec%0d valid_o", i), 64'(m_valid), 64'(tbl[i].e_v));
         check($sformatf("vec%0d data_o", i), 64'(m_data), 64'(tbl[i].e_d));
         check($sformatf("vec%0d overflow_o", i), 64'(m_ovf), 64'd0);
      end

      // overflow: 200+100 in 8 bits
      drive(1, 200, 2, 1, 0);
      drive(1, 100, 2, 1, 0);
      check("wrap valid_o", 64'(w_valid), 64'd1);
      check("wrap data_o", 64'(w_data), 64'd44);
      check("wrap overflow_o", 64'(w_ovf), 64'd1);
      check("sat data_o", 64'(s_data), 64'd255);
      check("sat overflow_o", 64'(s_ovf), 64'd1);
      check("wide data_o", 64'(m_data), 64'd300);
      check("wide overflow_o", 64'(m_ovf), 64'd0);
      // next frame must not inherit the flag
      drive(1, 1, 2, 1, 0);
      drive(1, 1, 2, 1, 0);
      check("wrap next data_o", 64'(w_data), 64'd2);
      check("wrap next overflow_o", 64'(w_ovf), 64'd0);
      check("sat next data_o", 64'(s_data), 64'd2);
      check("sat next overflow_o", 64'(s_ovf), 64'd0);
      // saturation sticks for the rest of the frame
      drive(1, 200, 3, 1, 0);
      drive(1, 100, 3, 1, 0);
      drive(1,   5, 3, 1, 0);
      check("wrap3 data_o", 64'(w_data), 64'd49);
      check("wrap3 overflow_o", 64'(w_ovf), 64'd1);
      check("sat3 data_o", 64'(s_data), 64'd255);
      check("sat3 overflow_o", 64'(s_ovf), 64'd1);
      check("wide3 data_o", 64'(m_data), 64'd305);
      drive(0, 0, 2, 1, 0);
      check("drain valid_o", 64'(m_valid), 64'd0);

      // async reset while an output is pending
      drive(1, 200, 2, 0, 0);
      drive(1, 100, 2, 0, 0);
      drive(0,   0, 2, 0, 0);
      check("pending valid_o", 64'(w_valid), 64'd1);
      check("pending overflow_o", 64'(w_ovf), 64'd1);
      reset_assert();
      check("async rst valid_o", 64'(m_valid), 64'd0);
      check("async rst data_o", 64'(m_data), 64'd0);
      check("async rst overflow_o", 64'(m_ovf), 64'd0);
      check("async rst wrap valid_o", 64'(w_valid), 64'd0);
      check("async rst wrap data_o", 64'(w_data), 64'd0);
      check("async rst wrap overflow_o", 64'(w_ovf), 64'd0);
      reset_release();

      // async reset with a partial frame
      drive(1, 50, 3, 1, 0);
      check("partial state", 64'(m_state), 64'(ACCUM));
      reset_assert();
      check("partial rst state", 64'(m_state), 64'(IDLE));
      reset_release();
      drive(1, 5, 3, 1, 0);
      drive(1, 6, 3, 1, 0);
      check("post rst no early valid", 64'(m_valid), 64'd0);
      drive(1, 7, 3, 1, 0);
      check("post rst valid_o", 64'(m_valid), 64'd1);
      check("post rst data_o", 64'(m_data), 64'd18);
      check("post rst overflow_o", 64'(m_ovf), 64'd0);
      check("post rst wrap data_o", 64'(w_data), 64'd18);
      drive(0, 0, 3, 1, 0);
      check("post rst drain", 64'(m_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
